// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port,
// guards memory accesses with a watchdog and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StRExec    = 4'd7,
    StRWb      = 4'd8,
    StBranch   = 4'd9,
    StJump     = 4'd10,
    StIExec    = 4'd11,
    StIWb      = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  // Wide enough to hold WAIT_LIMIT itself without wrapping.
  localparam int unsigned     WaitW    = $clog2(WAIT_LIMIT + 2);
  localparam bit              WdogEn   = (WAIT_LIMIT != 0);
  localparam logic [WaitW-1:0] WaitLast = WdogEn ? WaitW'(WAIT_LIMIT - 1) : '0;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             req_state;
  logic             timeout;

  // Derived from state only, so the watchdog does not loop through the output decoder.
  assign req_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  assign timeout   = WdogEn && req_state && !mem_ready && (wait_q == WaitLast);
  assign wait_d    = (req_state && !mem_ready) ? wait_q + 1'b1 : '0;
  assign count_d   = instr_done ? count_q + 1'b1 : count_q;

  assign instr_count = count_q;
  assign state       = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_error  = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (timeout) begin
          bus_error = 1'b1;
          state_d   = StIdle;
        end else if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        alu_src_b = 2'b11;
        unique case (opcode)
          OpRType:    state_d = StRExec;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StIExec;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (timeout) begin
          bus_error = 1'b1;
          state_d   = StIdle;
        end else if (mem_ready) begin
          state_d = StMemWb;
        end
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (timeout) begin
          bus_error = 1'b1;
          state_d   = StIdle;
        end else if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = StFetch;
        end
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_source  = 2'b01;
        pc_write   = alu_zero;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StIWb;
      end
      StIWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a driver plans instructions and memory delays, pushes the
// expected terminating event of each attempt, and a monitor compares it when the DUT signals it.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned WAIT_LIMIT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       opcode;
  logic             alu_zero;
  logic             mem_ready;
  logic             mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]       pc_source, alu_src_b, alu_op;
  logic             alu_src_a, reg_dst, mem_to_reg, reg_write;
  logic             instr_done, illegal_op, bus_error;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  multicycle_ctrl #(
    .CNT_W      (CNT_W),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_source   (pc_source),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .bus_error   (bus_error),
    .instr_count (instr_count),
    .state       (state)
  );

  always #5 clk = ~clk;

  // kind: 0 retired, 1 illegal opcode, 2 bus error; gap counts cycles since the previous event.
  typedef struct packed {
    logic [1:0]       kind;
    logic [7:0]       gap;
    logic [3:0]       st;
    logic [CNT_W-1:0] cnt;
    logic             pcw;
    logic [1:0]       pcs;
    logic             rw;
    logic             rd;
    logic             m2r;
    logic             we;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               extra  = 1;
  int               mon_cyc = 0;
  bit               mon_en = 1'b0;
  logic [CNT_W-1:0] cnt_model = '0;
  logic [17:0]      outs;

  assign outs = {mem_req, mem_we, iord, ir_write, pc_write, pc_source, alu_src_a, alu_src_b,
                 alu_op, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, bus_error};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Memory responder: noise on mem_ready while idle, then `waits` stall cycles and one ready.
  task automatic mem_access(input int waits, input bit timeout);
    int guard = 0;
    while (mem_req !== 1'b1) begin
      if (guard == 50) begin
        check("access_wait", 32'd0, 32'd1);
        return;
      end
      mem_ready = 1'($urandom_range(0, 1));
      guard++;
      @(negedge clk);
    end
    repeat (waits) begin
      mem_ready = 1'b0;
      @(negedge clk);
    end
    if (!timeout) begin
      mem_ready = 1'b1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  task automatic run_instr();
    int         cls = int'($urandom_range(0, 6));
    bit         z   = 1'($urandom_range(0, 1));
    bit         fin = 1'b0;
    logic [5:0] op;
    logic [5:0] bad_ops [4];
    bad_ops = '{6'b111111, 6'b000001, 6'b001001, 6'b100000};
    case (cls)
      0: op = 6'b100011;
      1: op = 6'b101011;
      2: op = 6'b000000;
      3: op = 6'b001000;
      4: op = 6'b000100;
      5: op = 6'b000010;
      default: op = bad_ops[$urandom_range(0, 3)];
    endcase
    while (!fin) begin
      int   fw = int'($urandom_range(0, 5));
      int   dw = int'($urandom_range(0, 5));
      exp_t e  = '0;
      e.cnt = cnt_model;
      if (fw >= int'(WAIT_LIMIT)) begin
        e.kind = 2; e.gap = 8'(extra + 4); e.st = 4'd1;
        exp_q.push_back(e);
        extra = 1;
        mem_access(4, 1'b1);
        continue;
      end
      if (cls <= 1 && dw >= int'(WAIT_LIMIT)) begin
        e.kind = 2; e.gap = 8'(extra + fw + 7); e.st = (cls == 0) ? 4'd4 : 4'd6;
        e.we = (cls == 1);
        exp_q.push_back(e);
        extra = 1;
        mem_access(fw, 1'b0);
        opcode = op; alu_zero = z;
        mem_access(4, 1'b1);
        continue;
      end
      case (cls)
        0: begin e.gap = 8'(5 + fw + dw); e.st = 4'd5;  e.rw = 1; e.m2r = 1; end
        1: begin e.gap = 8'(4 + fw + dw); e.st = 4'd6;  e.we = 1; end
        2: begin e.gap = 8'(4 + fw);      e.st = 4'd8;  e.rw = 1; e.rd = 1; end
        3: begin e.gap = 8'(4 + fw);      e.st = 4'd12; e.rw = 1; end
        4: begin e.gap = 8'(3 + fw);      e.st = 4'd9;  e.pcw = z; e.pcs = 2'b01; end
        5: begin e.gap = 8'(3 + fw);      e.st = 4'd10; e.pcw = 1; e.pcs = 2'b10; end
        default: begin e.kind = 1; e.gap = 8'(2 + fw); e.st = 4'd2; end
      endcase
      e.gap = e.gap + 8'(extra);
      exp_q.push_back(e);
      if (e.kind == 0) cnt_model = cnt_model + 1'b1;
      extra = 0;
      mem_access(fw, 1'b0);
      opcode = op; alu_zero = z;
      if (cls <= 1) mem_access(dw, 1'b0);
      fin = 1'b1;
    end
  endtask

  // Monitor: samples mid-cycle, well clear of both edges.
  initial begin
    exp_t       e;
    logic [1:0] k;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en || rst) begin
        mon_cyc = 0;
        continue;
      end
      mon_cyc++;
      if (instr_done || illegal_op || bus_error) begin
        check("one_event", $countones({instr_done, illegal_op, bus_error}), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          k = bus_error ? 2'd2 : (illegal_op ? 2'd1 : 2'd0);
          check("kind", k, e.kind);
          check("gap", mon_cyc, e.gap);
          check("state", state, e.st);
          check("count", instr_count, e.cnt);
          check("pc_write", pc_write, e.pcw);
          check("pc_source", pc_source, e.pcs);
          check("reg_write", reg_write, e.rw);
          check("reg_dst", reg_dst, e.rd);
          check("mem_to_reg", mem_to_reg, e.m2r);
          check("mem_we", mem_we, e.we);
          if (k == 2'd2) check("buserr_ir_write", ir_write, 1'b0);
        end
        mon_cyc = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = 6'd0; alu_zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", outs, 18'd0);
    check("reset_state", state, 4'd0);
    check("reset_count", instr_count, 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int n = 0; n < 60; n++) run_instr();
    for (int g = 0; g < 40 && exp_q.size() != 0; g++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    mon_en = 1'b0;
    check("final_count", instr_count, cnt_model);
    // Reset mid-instruction: R-type taken into R_EXEC, then rst asserted.
    mem_access(0, 1'b0);
    opcode = 6'b000000;
    for (int g = 0; g < 10 && state != 4'd7; g++) @(negedge clk);
    check("reach_rexec", state, 4'd7);
    rst = 1'b1;
    #1;
    check("midrst_outs", outs, 18'd0);
    check("midrst_state", state, 4'd0);
    check("midrst_count", instr_count, 0);
    @(negedge clk);
    check("midrst_hold", state, 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
